// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: round-robin arbiter that frames requester packets into the FT232H bridge TX FIFO after a space check
module usb_tx_scheduler #(
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 512,
    parameter int FIFO_WIDTHU = 9,
    parameter int POLL_GAP    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   req,
    input  logic [8*NUM_CH-1:0] req_len,
    output logic [NUM_CH-1:0]   gnt,
    input  logic [8*NUM_CH-1:0] src_data,
    input  logic [NUM_CH-1:0]   src_valid,
    output logic [NUM_CH-1:0]   src_ready,
    output logic [3:0]          avm_address,
    output logic                avm_read,
    input  logic [7:0]          avm_readdata,
    output logic                avm_write,
    output logic [7:0]          avm_writedata,
    output logic                busy,
    output logic [15:0]         pkt_count
);
    localparam int GW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
    localparam int UW = FIFO_WIDTHU + 1;
    typedef enum logic [3:0] {IDLE, RD_L, RD_H, EVAL, WAIT, HDR, LEN, DATA, DONE} state_t;
    state_t            r_state;
    logic [GW-1:0]     r_g, r_rr, w_pick;
    logic [7:0]        r_len, r_rem, r_stl, r_wdata;
    logic [CW-1:0]     r_cnt;
    logic [NUM_CH-1:0] r_gnt;
    logic              r_rd, r_wr;
    logic [3:0]        r_addr;
    logic [15:0]       r_pkt, w_status;
    logic [UW-1:0]     w_used, w_free;
    logic              w_fits, w_acc, w_unused;
    // first pending requester at or after the round-robin pointer, wrapping
    always_comb begin
        w_pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (req[(int'(r_rr) + k) % NUM_CH]) w_pick = GW'((int'(r_rr) + k) % NUM_CH);
    end
    assign w_status      = {avm_readdata, r_stl};
    assign w_unused      = ^w_status;
    assign w_used        = w_status[FIFO_WIDTHU] ? UW'(FIFO_DEPTH) : {1'b0, w_status[FIFO_WIDTHU-1:0]};
    assign w_free        = UW'(FIFO_DEPTH) - w_used;
    assign w_fits        = 11'(w_free) >= 11'(r_len) + 11'd2;
    assign w_acc         = (r_state == DATA) && src_valid[r_g];
    assign gnt           = r_gnt;
    assign src_ready     = (r_state == DATA) ? r_gnt : '0;
    assign avm_read      = r_rd;
    assign avm_write     = r_wr | w_acc;
    assign avm_address   = r_addr;
    assign avm_writedata = (r_state == DATA) ? src_data[8*r_g +: 8] : r_wdata;
    assign busy          = r_state != IDLE;
    assign pkt_count     = r_pkt;
    // packet FSM: grant, poll TX status until the whole frame fits, then stream header, length and payload
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_rr    <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_stl   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pkt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (|req) begin
                    r_g     <= w_pick;
                    r_len   <= req_len[8*w_pick +: 8];
                    r_gnt   <= NUM_CH'(1) << w_pick;
                    r_rd    <= 1'b1;
                    r_addr  <= 4'd2;
                    r_state <= RD_L;
                end
                RD_L: begin
                    r_addr  <= 4'd3;
                    r_state <= RD_H;
                end
                RD_H: begin
                    r_stl   <= avm_readdata;
                    r_rd    <= 1'b0;
                    r_addr  <= 4'd0;
                    r_state <= EVAL;
                end
                EVAL: if (w_fits) begin
                    r_wr    <= 1'b1;
                    r_wdata <= 8'hA0 | 8'(r_g);
                    r_state <= HDR;
                end else if (POLL_GAP <= 1) begin
                    r_rd    <= 1'b1;
                    r_addr  <= 4'd2;
                    r_state <= RD_L;
                end else begin
                    r_cnt   <= CW'(POLL_GAP > 1 ? POLL_GAP - 2 : 0);
                    r_state <= WAIT;
                end
                WAIT: if (r_cnt == '0) begin
                    r_rd    <= 1'b1;
                    r_addr  <= 4'd2;
                    r_state <= RD_L;
                end else r_cnt <= r_cnt - 1'b1;
                HDR: begin
                    r_wdata <= r_len;
                    r_state <= LEN;
                end
                LEN: begin
                    r_wr    <= 1'b0;
                    r_wdata <= '0;
                    r_rem   <= r_len;
                    r_state <= (r_len == 8'd0) ? DONE : DATA;
                end
                DATA: if (src_valid[r_g]) begin
                    r_rem <= r_rem - 8'd1;
                    if (r_rem == 8'd1) r_state <= DONE;
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_pkt   <= r_pkt + 16'd1;
                    r_rr    <= GW'((int'(r_g) + 1) % NUM_CH);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: table, directed and random checks of usb_tx_scheduler against a bridge/source model
module tb_usb_tx_scheduler;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req = '0, gnt, src_valid = '0, src_ready;
    logic [15:0] req_len = '0, src_data = '0, pkt_count;
    logic [3:0]  avm_address;
    logic        avm_read, avm_write, busy;
    logic [7:0]  avm_readdata = '0, avm_writedata;

    usb_tx_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .gnt(gnt),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int len; int used; int lat; int gcyc;} vec_t;
    vec_t       tbl[6];
    int         tests = 0, fails = 0, cyc = 0, inv_err = 0;
    int         t_first_wr = -1, sr_cnt = 0, nacc = 0, first_act = -1;
    int         gcnt[2];
    int         st_used = 0, rr_m = 0, pkt_m = 0;
    bit         st_full = 0, phase = 0, rd_pend = 0;
    bit [1:0]   gap = '0, acc = '0;
    logic [3:0] rd_addr = '0;
    bit [7:0]   src_q[2][$];
    bit [7:0]   expq[2][$];
    bit [7:0]   wq[$];
    int         rdq[$];

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_q(input string name, input bit [7:0] e[$]);
        int bad = -1;
        tests++;
        if (wq.size() != e.size()) bad = 0;
        else for (int i = e.size() - 1; i >= 0; i--) if (wq[i] != e[i]) bad = i;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: got %0d bytes expected %0d bytes, first diff at %0d got %h expected %h",
                     name, wq.size(), e.size(), bad,
                     bad < wq.size() ? wq[bad] : 8'h00, bad < e.size() ? e[bad] : 8'h00);
        end
    endtask

    function automatic int pick(input bit [1:0] m, input int rr);
        for (int k = 0; k < 2; k++) if (m[(rr + k) % 2]) return (rr + k) % 2;
        return -1;
    endfunction

    // one clock: bridge and sources react after the edge, DUT outputs are sampled on the falling edge
    task automatic step();
        logic [15:0] st;
        @(posedge clk);
        #1;
        st = 16'(st_used) | (st_full ? 16'h0200 : 16'h0000);
        avm_readdata = rd_pend ? (rd_addr == 4'd2 ? st[7:0] : st[15:8]) : 8'h00;
        phase = ~phase;
        for (int c = 0; c < 2; c++) begin
            if (acc[c]) void'(src_q[c].pop_front());
            src_valid[c] = src_q[c].size() > 0 && (!gap[c] || phase);
            src_data[c*8 +: 8] = src_q[c].size() > 0 ? src_q[c][0] : 8'h00;
        end
        @(negedge clk);
        cyc++;
        rd_pend = avm_read;
        rd_addr = avm_address;
        if (first_act < 0 && (avm_read || avm_write)) first_act = avm_write ? 16 + int'(avm_address) : int'(avm_address);
        if (avm_write) begin
            if (avm_address != 4'd0) inv_err++;
            wq.push_back(avm_writedata);
            if (t_first_wr < 0) t_first_wr = cyc;
        end
        if (avm_read && avm_write) inv_err++;
        if (avm_read && avm_address == 4'd2) rdq.push_back(cyc);
        if (|(src_ready & ~gnt)) inv_err++;
        if ($countones(gnt) > 1) inv_err++;
        for (int c = 0; c < 2; c++) begin
            acc[c] = src_valid[c] & src_ready[c];
            if (gnt[c]) gcnt[c]++;
            if (src_ready[c]) sr_cnt++;
            if (acc[c]) nacc++;
        end
    endtask

    task automatic load(input int c, input int len);
        bit [7:0] b;
        expq[c].delete();
        expq[c].push_back(8'hA0 | 8'(c));
        expq[c].push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            src_q[c].push_back(b);
            expq[c].push_back(b);
        end
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while (busy && t < bound) begin step(); t++; end
    endtask

    // requests the channels in mask together and checks grant order, framed bytes and packet count
    task automatic serve(input bit [1:0] mask, input int l0, input int l1, input bit [1:0] gp);
        bit [1:0] pend = mask;
        int t, g, it = 0;
        gap = gp;
        if (mask[0]) load(0, l0);
        if (mask[1]) load(1, l1);
        req_len = {8'(l1), 8'(l0)};
        req = mask;
        while (pend != 0 && it < 4) begin
            it++;
            wq.delete();
            t = 0;
            while (gnt == 0 && t < 50) begin step(); t++; end
            chk("grant_seen", gnt != 0, 1);
            if (gnt == 0) begin
                req = '0;
                pend = '0;
            end else begin
                g = gnt[1] ? 1 : 0;
                chk("grant_order", g, pick(pend, rr_m));
                req[g] = 1'b0;
                pend[g] = 1'b0;
                wait_idle(600);
                chk("pkt_done", busy, 0);
                chk_q("pkt_bytes", expq[g]);
                pkt_m++;
                chk("pkt_count", pkt_count, pkt_m);
                rr_m = (g + 1) % 2;
            end
        end
        req = '0;
    endtask

    initial begin
        bit [7:0] part[$];
        int bad, t_req;
        tbl[0] = '{0, 3, 0, 4, 9};
        tbl[1] = '{1, 0, 0, 4, 6};
        tbl[2] = '{0, 1, 0, 4, 7};
        tbl[3] = '{1, 255, 255, 4, 261};
        tbl[4] = '{0, 10, 500, 4, 16};
        tbl[5] = '{1, 2, 508, 4, 8};

        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt", pkt_count, 0);
        reset = 1'b0;
        step();

        serve(2'b11, 1, 1, 2'b00);
        serve(2'b11, 1, 1, 2'b00);
        sr_cnt = 0;
        serve(2'b01, 0, 0, 2'b00);
        chk("len0_no_ready", sr_cnt, 0);

        foreach (tbl[i]) begin
            st_used = tbl[i].used;
            st_full = 0;
            gap = '0;
            load(tbl[i].ch, tbl[i].len);
            req_len[tbl[i].ch*8 +: 8] = 8'(tbl[i].len);
            wq.delete();
            gcnt = '{0, 0};
            t_first_wr = -1;
            t_req = cyc;
            req[tbl[i].ch] = 1'b1;
            step();
            req = '0;
            wait_idle(600);
            chk("tbl_done", busy, 0);
            chk("tbl_hdr_latency", t_first_wr - t_req, tbl[i].lat);
            chk("tbl_gnt_cycles", gcnt[tbl[i].ch], tbl[i].gcyc);
            chk_q("tbl_bytes", expq[tbl[i].ch]);
            pkt_m++;
            chk("tbl_pkt_count", pkt_count, pkt_m);
            rr_m = (tbl[i].ch + 1) % 2;
        end

        for (int r = 0; r < 25; r++) begin
            st_used = $urandom_range(0, 400);
            serve(2'($urandom_range(1, 3)), $urandom_range(0, 20), $urandom_range(0, 20), 2'($urandom_range(0, 3)));
        end

        st_used = 510;
        gap = '0;
        load(0, 3);
        req_len[7:0] = 8'd3;
        wq.delete();
        rdq.delete();
        req[0] = 1'b1;
        step();
        req = '0;
        repeat (60) step();
        chk("poll_no_write", wq.size(), 0);
        chk("poll_repolled", rdq.size() >= 3, 1);
        bad = 0;
        for (int i = 1; i < rdq.size(); i++) if (rdq[i] - rdq[i-1] != 18) bad++;
        chk("poll_period", bad, 0);
        st_used = 507;
        wait_idle(100);
        chk("poll_done", busy, 0);
        chk_q("poll_bytes", expq[0]);
        pkt_m++;
        chk("poll_pkt_count", pkt_count, pkt_m);
        rr_m = 1;

        st_used = 0;
        st_full = 1;
        load(1, 2);
        req_len[15:8] = 8'd2;
        wq.delete();
        rdq.delete();
        req[1] = 1'b1;
        step();
        req = '0;
        repeat (40) step();
        chk("full_no_write", wq.size(), 0);
        chk("full_polled", rdq.size() >= 2, 1);
        st_full = 0;
        wait_idle(100);
        chk("full_done", busy, 0);
        chk_q("full_bytes", expq[1]);
        pkt_m++;
        chk("full_pkt_count", pkt_count, pkt_m);
        rr_m = 0;

        gap = 2'b01;
        load(0, 4);
        req_len[7:0] = 8'd4;
        wq.delete();
        nacc = 0;
        req[0] = 1'b1;
        step();
        req = '0;
        bad = 0;
        while (nacc < 2 && bad < 100) begin step(); bad++; end
        chk("mid_two_bytes", nacc, 2);
        reset = 1'b1;
        step();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_ready", src_ready, 0);
        chk("mid_rst_read", avm_read, 0);
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_addr", avm_address, 0);
        chk("mid_rst_wdata", avm_writedata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pkt", pkt_count, 0);
        part = expq[0][0:3];
        chk_q("mid_partial_bytes", part);
        reset = 1'b0;
        src_q[0].delete();
        gap = '0;
        pkt_m = 0;
        rr_m = 0;
        step();
        first_act = -1;
        serve(2'b10, 0, 1, 2'b00);
        chk("post_rst_first_access", first_act, 2);

        chk("invariants", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
